// File: rtl/soc_io_seg7_ctrl.sv
// Eight-digit seven-segment controller: register writes trigger a refresh scan
// through one shared registered hex decoder. Optional macro: SOC_IO_SEG7_LEADING_ZERO_BLANK_EN.
module soc_io_seg7_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        busy,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic            ready_q;
    logic [7:0][3:0] digit_q, digit_d;
    logic [7:0]      mask_q, mask_d;
    logic [6:0]      dec_q;
    logic [6:0]      hex_q [8];
    logic [7:0]      blank;
    logic [3:0]      dec_in;
    logic            accept;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ready_q holds wr_ready low for the first cycle after reset release
    assign wr_ready = ready_q && (state_q == ST_IDLE);
    assign busy     = (state_q == ST_SCAN);
    assign accept   = wr_valid && wr_ready;
    assign dec_in   = digit_q[idx_q[2:0]];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = 4'd0;
                if (accept) begin
                    case (wr_addr)
                        2'd0: begin
                            digit_d[3:0] = wr_data;
                            state_d      = ST_SCAN;
                        end
                        2'd1: begin
                            digit_d[7:4] = wr_data;
                            state_d      = ST_SCAN;
                        end
                        2'd2: begin
                            mask_d  = wr_data[7:0];
                            state_d = ST_SCAN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SCAN: begin
                if (idx_q == 4'd8) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            ready_q <= 1'b0;
            digit_q <= '0;
            mask_q  <= 8'hFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= 1'b1;
            digit_q <= digit_d;
            mask_q  <= mask_d;
        end
    end

    // Shared decoder stage: digit i enters in scan cycle i, result is captured one cycle later
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dec_q <= 7'b1111111;
        end else if (busy && !idx_q[3]) begin
            dec_q <= seg7(dec_in);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
`ifdef SOC_IO_SEG7_LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_lsd
                assign blank[gi] = mask_q[gi];
            end else begin : g_lz
                assign blank[gi] = mask_q[gi] || (digit_q[7:gi] == '0);
            end
`else
            assign blank[gi] = mask_q[gi];
`endif
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    hex_q[gi] <= 7'b1111111;
                end else if (busy && (idx_q == 4'(gi + 1))) begin
                    hex_q[gi] <= blank[gi] ? 7'b1111111 : dec_q;
                end
            end
        end
    endgenerate

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];

endmodule

// File: tb/tb_soc_io_seg7_ctrl.sv
// Self-checking bench for soc_io_seg7_ctrl: table of register writes with
// expected digit patterns, plus timing, back-to-back and mid-scan reset sequences.
module tb_soc_io_seg7_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [6:0]  hx [8];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]      addr;
        logic [15:0]     data;
        logic [7:0][6:0] exp;
    } vec_t;

    soc_io_seg7_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .hex6     (hex6),
        .hex7     (hex7)
    );

    always #5 clk = ~clk;

    assign hx[0] = hex0;
    assign hx[1] = hex1;
    assign hx[2] = hex2;
    assign hx[3] = hex3;
    assign hx[4] = hex4;
    assign hx[5] = hex5;
    assign hx[6] = hex6;
    assign hx[7] = hex7;

    function automatic logic [7:0][6:0] p8(input logic [6:0] h0, h1, h2, h3, h4, h5, h6, h7);
        logic [7:0][6:0] r;
        r[0] = h0; r[1] = h1; r[2] = h2; r[3] = h3;
        r[4] = h4; r[5] = h5; r[6] = h6; r[7] = h7;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic check_hex(input string tag, input logic [7:0][6:0] exp);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s hex%0d", tag, k), {25'd0, hx[k]}, {25'd0, exp[k]});
    endtask

    // Issue one write, wait for its scan to finish; returns busy seen right after the handshake
    task automatic do_write(input logic [1:0] a, input logic [15:0] d, output logic busy_after);
        int t;
        busy_after = 1'b0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        t = 0;
        while (!wr_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("accept", {31'd0, wr_ready}, 32'd1);
        if (wr_ready) begin
            @(posedge clk);
            @(negedge clk);
            busy_after = busy;
        end
        wr_valid = 1'b0;
        t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("scan_done", {31'd0, busy}, 32'd0);
        $display("write addr=%0d data=%04h busy_after=%0b hex=%02h %02h %02h %02h %02h %02h %02h %02h",
                 a, d, busy_after, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7);
    endtask

    initial begin
        vec_t  vecs [12];
        logic  b;
        int    n, busy_cnt, hs;
        logic [6:0] all_f;

        all_f    = 7'h7F;
        resetn   = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 16'd0;

        // Reset applied between clock edges must act immediately
        #2 resetn = 1'b0;
        #1;
        check_hex("reset", p8(all_f, all_f, all_f, all_f, all_f, all_f, all_f, all_f));
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset wr_ready", {31'd0, wr_ready}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1 check("ready before edge", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        check("ready after edge", {31'd0, wr_ready}, 32'd1);
        check("idle busy", {31'd0, busy}, 32'd0);
        $display("reset done ready=%0b busy=%0b", wr_ready, busy);

`ifdef SOC_IO_SEG7_LEADING_ZERO_BLANK_EN
        do_write(2'd0, 16'h0500, b);
        do_write(2'd1, 16'h0000, b);
        do_write(2'd2, 16'h0000, b);
        check_hex("lzb", p8(7'h40, 7'h40, 7'h12, all_f, all_f, all_f, all_f, all_f));
`else
        vecs[0]  = '{2'd2, 16'h0000, p8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)};
        vecs[1]  = '{2'd0, 16'h3210, p8(7'h40, 7'h79, 7'h24, 7'h30, 7'h40, 7'h40, 7'h40, 7'h40)};
        vecs[2]  = '{2'd1, 16'hFEDC, p8(7'h40, 7'h79, 7'h24, 7'h30, 7'h46, 7'h21, 7'h06, 7'h0E)};
        vecs[3]  = '{2'd3, 16'hFFFF, p8(7'h40, 7'h79, 7'h24, 7'h30, 7'h46, 7'h21, 7'h06, 7'h0E)};
        vecs[4]  = '{2'd0, 16'h9876, p8(7'h02, 7'h78, 7'h00, 7'h18, 7'h46, 7'h21, 7'h06, 7'h0E)};
        vecs[5]  = '{2'd1, 16'hBA54, p8(7'h02, 7'h78, 7'h00, 7'h18, 7'h19, 7'h12, 7'h08, 7'h03)};
        vecs[6]  = '{2'd2, 16'hFF0F, p8(all_f, all_f, all_f, all_f, 7'h19, 7'h12, 7'h08, 7'h03)};
        vecs[7]  = '{2'd2, 16'h00F0, p8(7'h02, 7'h78, 7'h00, 7'h18, all_f, all_f, all_f, all_f)};
        vecs[8]  = '{2'd0, 16'h0505, p8(7'h12, 7'h40, 7'h12, 7'h40, all_f, all_f, all_f, all_f)};
        vecs[9]  = '{2'd1, 16'h0000, p8(7'h12, 7'h40, 7'h12, 7'h40, all_f, all_f, all_f, all_f)};
        vecs[10] = '{2'd2, 16'h000F, p8(all_f, all_f, all_f, all_f, 7'h40, 7'h40, 7'h40, 7'h40)};
        vecs[11] = '{2'd2, 16'h0000, p8(7'h12, 7'h40, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)};

        for (int i = 0; i < 12; i++) begin
            do_write(vecs[i].addr, vecs[i].data, b);
            check($sformatf("vec%0d busy", i), {31'd0, b}, {31'd0, (vecs[i].addr != 2'd3)});
            check_hex($sformatf("vec%0d", i), vecs[i].exp);
        end

        // wr_valid held across a scan: hex0 timing, busy length, next accept point
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 2'd0;
        wr_data  = 16'h1111;
        check("b2b ready", {31'd0, wr_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        wr_data  = 16'h2222;
        n        = 0;
        busy_cnt = 0;
        hs       = 0;
        while (hs == 0 && n < 30) begin
            if (busy) busy_cnt++;
            if (n == 1) check("hex0 held at E1", {25'd0, hex0}, 32'h12);
            if (n == 2) check("hex0 new at E2", {25'd0, hex0}, 32'h79);
            if (n == 2) check("hex1 held at E2", {25'd0, hex1}, 32'h40);
            if (n == 3) check("hex1 new at E3", {25'd0, hex1}, 32'h79);
            if (n == 8) check("hex7 held at E8", {25'd0, hex7}, 32'h40);
            if (n == 8) check("ready low at E8", {31'd0, wr_ready}, 32'd0);
            if (wr_ready) begin
                @(posedge clk);
                n++;
                hs = n;
            end else begin
                @(posedge clk);
                n++;
            end
            @(negedge clk);
        end
        // Scan returns to IDLE at E9, so the held request is accepted at E10
        check("b2b busy cycles", busy_cnt, 32'd9);
        check("b2b second accept edge", hs, 32'd10);
        wr_valid = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_hex("b2b", p8(7'h24, 7'h24, 7'h24, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40));
        $display("back-to-back accept_edge=%0d busy_cycles=%0d hex0=%02h", hs, busy_cnt, hex0);
`endif

        // Reset in scan cycle 4 aborts the refresh for good
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 2'd1;
        wr_data  = 16'h7777;
        check("abort ready", {31'd0, wr_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort busy before reset", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check_hex("abort", p8(all_f, all_f, all_f, all_f, all_f, all_f, all_f, all_f));
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort ready low", {31'd0, wr_ready}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        check("post-abort busy", {31'd0, busy}, 32'd0);
        check("post-abort ready", {31'd0, wr_ready}, 32'd1);
        check_hex("post-abort", p8(all_f, all_f, all_f, all_f, all_f, all_f, all_f, all_f));
        $display("abort busy=%0b ready=%0b hex0=%02h hex7=%02h", busy, wr_ready, hex0, hex7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
